// File: rtl/arbiter_cell.sv
// Daisy-chain priority arbiter cell: lowest-indexed requester takes the incoming
// token; with no requester the token ripples out on cout to the next cell.
module arbiter_cell #(
  parameter int N         = 1,
  parameter bit REG_GRANT = 1'b1,
  localparam int GW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  r,
  input  logic          cin,
  output logic [N-1:0]  g,
  output logic          cout,
  output logic          gany,
  output logic [GW-1:0] gidx
);

  logic [N:0]    c;
  logic [N-1:0]  gc;
  logic [N-1:0]  g_sel;
  logic [GW-1:0] idx_d;

  // Token ripple: a slice consumes the token when it requests, otherwise passes it on.
  // NOTE: every signal written in always_comb gets a value before any condition,
  // so no path through the block can leave it holding state (no latch).
  always_comb begin
    c    = '0;
    gc   = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      gc[i]  = c[i] & r[i];
      c[i+1] = c[i] & ~r[i];
    end
  end

  // cout never passes through a register so a whole chain settles in one cycle.
  assign cout = c[N];

  generate
    if (REG_GRANT) begin : g_registered
      logic [N-1:0] g_q;
      logic [N-1:0] g_d;

      assign g_d = gc;

      // NOTE: sequential state uses non-blocking assignments; reset is sampled
      // on the clock edge and wins over a simultaneous request.
      always_ff @(posedge clk) begin
        if (rst) g_q <= '0;
        else     g_q <= g_d;
      end

      assign g_sel = g_q;
    end else begin : g_combinational
      assign g_sel = gc;
    end
  endgenerate

  // One-hot to binary: OR of the indices of set bits, exact while g_sel is one-hot.
  always_comb begin
    idx_d = '0;
    for (int i = 0; i < N; i++) begin
      if (g_sel[i]) idx_d = idx_d | GW'(i);
    end
  end

  assign g    = g_sel;
  assign gany = |g_sel;
  assign gidx = idx_d;

  a_grant_onehot0: assert property (@(posedge clk) $onehot0(g));
  a_chain_onehot0: assert property (@(posedge clk) $onehot0(gc));

endmodule

// File: tb/tb_arbiter_cell.sv
// Directed and table-driven bench for arbiter_cell: N=1 registered, N=4
// registered and N=4 combinational instances share one clock and reset.
module tb_arbiter_cell;

  logic clk = 1'b0;
  always #3 clk = ~clk;

  logic       rst;
  logic       r1, cin1, g1, cout1, gany1;
  logic [0:0] gidx1;
  logic [3:0] r4, g4, g4c;
  logic       cin4, cout4, cout4c, gany4, gany4c;
  logic [1:0] gidx4, gidx4c;

  arbiter_cell #(.N(1), .REG_GRANT(1'b1)) u_n1 (
    .clk(clk), .rst(rst), .r(r1), .cin(cin1),
    .g(g1), .cout(cout1), .gany(gany1), .gidx(gidx1)
  );

  arbiter_cell #(.N(4), .REG_GRANT(1'b1)) u_n4 (
    .clk(clk), .rst(rst), .r(r4), .cin(cin4),
    .g(g4), .cout(cout4), .gany(gany4), .gidx(gidx4)
  );

  arbiter_cell #(.N(4), .REG_GRANT(1'b0)) u_n4c (
    .clk(clk), .rst(rst), .r(r4), .cin(cin4),
    .g(g4c), .cout(cout4c), .gany(gany4c), .gidx(gidx4c)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] prio4(input logic cin_v, input logic [3:0] r_v);
    logic [3:0] res;
    logic       done;
    res  = '0;
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cin_v && r_v[i] && !done) begin
        res[i] = 1'b1;
        done   = 1'b1;
      end
    end
    return res;
  endfunction

  typedef struct {
    logic       cin;
    logic [3:0] r;
    logic [3:0] g;
    logic       gany;
    logic [1:0] gidx;
    logic       cout;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [3:0] exp_g;

    vecs[0] = '{cin: 1'b1, r: 4'b0110, g: 4'b0010, gany: 1'b1, gidx: 2'd1, cout: 1'b0};
    vecs[1] = '{cin: 1'b1, r: 4'b0000, g: 4'b0000, gany: 1'b0, gidx: 2'd0, cout: 1'b1};
    vecs[2] = '{cin: 1'b0, r: 4'b1111, g: 4'b0000, gany: 1'b0, gidx: 2'd0, cout: 1'b0};
    vecs[3] = '{cin: 1'b1, r: 4'b1000, g: 4'b1000, gany: 1'b1, gidx: 2'd3, cout: 1'b0};
    vecs[4] = '{cin: 1'b1, r: 4'b1111, g: 4'b0001, gany: 1'b1, gidx: 2'd0, cout: 1'b0};
    vecs[5] = '{cin: 1'b1, r: 4'b1100, g: 4'b0100, gany: 1'b1, gidx: 2'd2, cout: 1'b0};
    vecs[6] = '{cin: 1'b0, r: 4'b0000, g: 4'b0000, gany: 1'b0, gidx: 2'd0, cout: 1'b0};

    rst = 1'b1; r1 = 1'b0; cin1 = 1'b0; r4 = '0; cin4 = 1'b0;
    step();
    check("rst_g4", g4, 4'b0000);
    check("rst_gany4", gany4, 1'b0);
    check("rst_gidx4", gidx4, 2'd0);
    check("rst_g1", g1, 1'b0);

    // During reset: cout and the combinational grant still follow the inputs.
    cin4 = 1'b1; r4 = 4'b0001;
    #1;
    check("rst_cout_passthru", cout4, 1'b0);
    check("rst_comb_g", g4c, 4'b0001);
    r4 = 4'b0000;
    #1;
    check("rst_cout_token", cout4, 1'b1);
    r4 = 4'b0001;
    step();
    check("rst_priority_g4", g4, 4'b0000);
    rst = 1'b0;

    // N=1 truth table, each pair held for two edges.
    for (int p = 0; p < 4; p++) begin
      cin1 = p[1];
      r1   = p[0];
      #1;
      check("n1_cout_now", cout1, p[1] & ~p[0]);
      if (p == 3) check("n1_g_before_edge", g1, 1'b0);
      for (int k = 0; k < 2; k++) begin
        step();
        check("n1_g", g1, p[1] & p[0]);
        check("n1_gany", gany1, p[1] & p[0]);
        check("n1_cout", cout1, p[1] & ~p[0]);
      end
    end

    // N=4 table vectors.
    for (int v = 0; v < 7; v++) begin
      cin4 = vecs[v].cin;
      r4   = vecs[v].r;
      #1;
      check("vec_cout", cout4, vecs[v].cout);
      check("vec_comb_g", g4c, vecs[v].g);
      check("vec_comb_gany", gany4c, vecs[v].gany);
      check("vec_comb_gidx", gidx4c, vecs[v].gidx);
      check("vec_comb_cout", cout4c, vecs[v].cout);
      step();
      check("vec_g", g4, vecs[v].g);
      check("vec_gany", gany4, vecs[v].gany);
      check("vec_gidx", gidx4, vecs[v].gidx);
    end

    // Random stimulus against the priority model.
    repeat (100) begin
      cin4 = 1'($urandom_range(0, 1));
      r4   = 4'($urandom);
      exp_g = prio4(cin4, r4);
      #1;
      check("rnd_cout", cout4, cin4 & ~(|r4));
      check("rnd_comb_g", g4c, exp_g);
      step();
      check("rnd_g", g4, exp_g);
      check("rnd_onehot0", $onehot0(g4), 1'b1);
    end

    // Reset asserted mid-grant, then grant returns; then preemption and release.
    cin4 = 1'b1; r4 = 4'b1000;
    step();
    check("mid_g_before", g4, 4'b1000);
    rst = 1'b1;
    #1;
    check("mid_cout_in_rst", cout4, 1'b0);
    step();
    check("mid_g_cleared", g4, 4'b0000);
    check("mid_gidx_cleared", gidx4, 2'd0);
    check("mid_gany_cleared", gany4, 1'b0);
    check("mid_cout_after", cout4, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_g_still_low", g4, 4'b0000);
    step();
    check("mid_g_back", g4, 4'b1000);
    check("mid_gidx_back", gidx4, 2'd3);
    r4 = 4'b1001;
    step();
    check("preempt_g", g4, 4'b0001);
    r4 = 4'b0000;
    #1;
    check("release_hold", g4, 4'b0001);
    step();
    check("release_g", g4, 4'b0000);
    check("release_cout", cout4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
